mseq_gen: RTL and testbench

MSEQ_GEN -- requirements
Module: mseq_gen

---
 rtl/mseq_pkg.sv | 25 ++
 rtl/mseq_if.sv | 70 +++++++
 rtl/mseq_step.sv | 24 ++
 rtl/mseq_gen.sv | 157 +++++++++++++++
 tb/tb_mseq_gen.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mseq_pkg.sv
// ---------------------------------------------------------------------------
// mseq_pkg
// Shared definitions for the maximal-length sequence generator:
//   - mseq_state_e        : generator FSM states (IDLE, RUN, STUCK)
//   - MSEQ_DEFAULT_SEED   : shift-register contents after reset
//   - MSEQ_DEFAULT_TAPS   : feedback tap mask after reset (x^5 + x^2 + 1)
// The constants are sized for the 5-bit default build; the generator casts
// them to its own WIDTH when forming its parameter defaults.
// ---------------------------------------------------------------------------
package mseq_pkg;

    // IDLE  : register loaded, no output offered
    // RUN   : out_bit offered every cycle, advancing on each transfer
    // STUCK : register holds all zeros and can never leave that state by
    //         shifting, so only load or reset gets the generator going again
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STUCK = 2'd2
    } mseq_state_e;

    localparam logic [4:0] MSEQ_DEFAULT_SEED = 5'b00001;
    localparam logic [4:0] MSEQ_DEFAULT_TAPS = 5'b00101;

endpackage

// File: rtl/mseq_if.sv
// ---------------------------------------------------------------------------
// mseq_if
// Control and data bundle between a consumer/controller (master) and the
// sequence generator (slave).
//   load, seed, taps_in : master -> slave, capture a new seed and tap mask
//   start, stop         : master -> slave, enter / leave generation
//   out_ready           : master -> slave, consumer accepts out_bit
//   out_valid, out_bit  : slave -> master, offered sequence bit
//   state_o             : slave -> master, current shift-register contents
//   stuck               : slave -> master, register is all zero
// Optional build macro MSEQ_PERIOD_CNT_EN adds:
//   period_done         : slave -> master, one-cycle pulse on period wrap
//   period_len          : slave -> master, length of the last full period
// ---------------------------------------------------------------------------
interface mseq_if #(
    parameter int WIDTH = 5
);

    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] taps_in;
    logic             start;
    logic             stop;
    logic             out_ready;
    logic             out_valid;
    logic             out_bit;
    logic [WIDTH-1:0] state_o;
    logic             stuck;
`ifdef MSEQ_PERIOD_CNT_EN
    logic             period_done;
    logic [WIDTH-1:0] period_len;
`endif

    // Controller / consumer side
    modport master (
        output load,
        output seed,
        output taps_in,
        output start,
        output stop,
        output out_ready,
        input  out_valid,
        input  out_bit,
        input  state_o,
`ifdef MSEQ_PERIOD_CNT_EN
        input  period_done,
        input  period_len,
`endif
        input  stuck
    );

    // Generator side
    modport slave (
        input  load,
        input  seed,
        input  taps_in,
        input  start,
        input  stop,
        input  out_ready,
        output out_valid,
        output out_bit,
        output state_o,
`ifdef MSEQ_PERIOD_CNT_EN
        output period_done,
        output period_len,
`endif
        output stuck
    );

endinterface

// File: rtl/mseq_step.sv
// ---------------------------------------------------------------------------
// mseq_step
// Purely combinational single step of a Fibonacci shift register.
//   state      : current register contents
//   taps       : feedback tap mask
//   sum        : XOR of the tapped bits; this is also the bit offered to the
//                consumer for the current state
//   next_state : contents after one shift, feedback entering at the MSB
// ---------------------------------------------------------------------------
module mseq_step #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic             sum,
    output logic [WIDTH-1:0] next_state
);

    // Feedback is the parity of the tapped bits; the register shifts toward
    // bit 0 and the new bit enters at the top.
    assign sum        = ^(state & taps);
    assign next_state = {sum, state[WIDTH-1:1]};

endmodule

// File: rtl/mseq_gen.sv
// ---------------------------------------------------------------------------
// mseq_gen
// Programmable-tap maximal-length sequence generator with a valid/ready
// output handshake.
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mseq_if slave modport (load/seed/taps_in, start/stop,
//          out_ready/out_valid/out_bit, state_o, stuck)
// Parameters:
//   WIDTH        : shift-register length (2..32)
//   DEFAULT_SEED : register contents after reset
//   DEFAULT_TAPS : tap mask after reset
// Build option:
//   MSEQ_PERIOD_CNT_EN : adds a step counter with period_done / period_len
//                        outputs, measured against a latched reference seed.
// ---------------------------------------------------------------------------
module mseq_gen
    import mseq_pkg::*;
#(
    parameter int               WIDTH        = 5,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(MSEQ_DEFAULT_SEED),
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(MSEQ_DEFAULT_TAPS)
) (
    input  logic clk,
    input  logic rst,
    mseq_if.slave bus
);

    mseq_state_e      fsm_q;
    mseq_state_e      fsm_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] taps_q;
    logic             step_sum;
    logic [WIDTH-1:0] step_next;
    logic             do_load;
    logic             do_adv;

    // One combinational step of the register from its current contents.
    mseq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .state      (lfsr_q),
        .taps       (taps_q),
        .sum        (step_sum),
        .next_state (step_next)
    );

    // Next-state decision. Load overrides everything, then stop, then start,
    // then a transfer. Start is only meaningful in IDLE and stop only in RUN,
    // so the two never compete within one state. A transfer happens only when
    // a bit is being offered (RUN) and taken, and if it would leave the
    // register empty we park in STUCK because shifting can never recover.
    always_comb begin
        fsm_d   = fsm_q;
        do_load = 1'b0;
        do_adv  = 1'b0;

        if (bus.load) begin
            do_load = 1'b1;
            fsm_d   = (bus.seed == '0) ? STUCK : IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.start) begin
                        fsm_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        fsm_d = IDLE;
                    end else if (bus.out_ready) begin
                        do_adv = 1'b1;
                        if (step_next == '0) begin
                            fsm_d = STUCK;
                        end
                    end
                end
                STUCK: begin
                    fsm_d = STUCK;
                end
                default: begin
                    fsm_d = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Shift register and tap mask. A load replaces both; a transfer shifts
    // once. Reset discards any transfer pending in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= DEFAULT_SEED;
            taps_q <= DEFAULT_TAPS;
        end else if (do_load) begin
            lfsr_q <= bus.seed;
            taps_q <= bus.taps_in;
        end else if (do_adv) begin
            lfsr_q <= step_next;
        end
    end

    // Outputs come straight from registered state, so nothing on the input
    // side of the handshake reaches them combinationally.
    assign bus.out_valid = (fsm_q == RUN);
    assign bus.stuck     = (fsm_q == STUCK);
    assign bus.out_bit   = step_sum;
    assign bus.state_o   = lfsr_q;

`ifdef MSEQ_PERIOD_CNT_EN
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] len_q;
    logic             done_q;

    // Period measurement. The reference is whatever seed the current run
    // started from; each transfer counts one step, and when a step lands back
    // on the reference the count (including that step) is published and the
    // counter restarts for the next lap. WIDTH bits are enough because a
    // maximal sequence is 2^WIDTH - 1 steps long.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q  <= DEFAULT_SEED;
            cnt_q  <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (do_load) begin
                ref_q <= bus.seed;
                cnt_q <= '0;
                len_q <= '0;
            end else if (do_adv) begin
                if (step_next == ref_q) begin
                    done_q <= 1'b1;
                    len_q  <= cnt_q + WIDTH'(1);
                    cnt_q  <= '0;
                end else begin
                    cnt_q  <= cnt_q + WIDTH'(1);
                end
            end
        end
    end

    assign bus.period_done = done_q;
    assign bus.period_len  = len_q;
`endif

endmodule

// File: tb/tb_mseq_gen.sv
// ---------------------------------------------------------------------------
// tb_mseq_gen
// Drives a 5-bit and an 8-bit mseq_gen with directed sequences and checks
// them every cycle against a behavioural model, plus literal expectations.
// Honours MSEQ_PERIOD_CNT_EN when defined.
// ---------------------------------------------------------------------------
module tb_mseq_gen;

    logic clk;
    logic rst;
    bit   checking;
    int   n_vec;
    int   n_err;

    mseq_if #(.WIDTH(5)) bus5 ();
    mseq_if #(.WIDTH(8)) bus8 ();

    mseq_gen #(.WIDTH(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    mseq_gen #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: register value, taps, run/stuck flags and the
    // period bookkeeping, all held as plain 32-bit numbers.
    typedef struct packed {
        logic [31:0] lfsr;
        logic [31:0] taps;
        logic [31:0] refs;
        logic [31:0] cnt;
        logic [31:0] len;
        logic        run;
        logic        stuck;
        logic        done;
    } model_t;

    model_t m5;
    model_t m8;

    function automatic logic model_parity(input logic [31:0] v);
        int ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) ones++;
        end
        return logic'(ones % 2);
    endfunction

    function automatic logic [31:0] model_next(input int w, input logic [31:0] s,
                                               input logic [31:0] t);
        logic fb = model_parity(s & t);
        return (s >> 1) | (32'(fb) << (w - 1));
    endfunction

    // One clock of the specification's rules: rst > load > stop > start > transfer.
    task automatic model_step(input int w, inout model_t m, input logic r,
                              input logic ld, input logic [31:0] sd,
                              input logic [31:0] tp, input logic go,
                              input logic halt, input logic rdy);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        logic [31:0] nxt;
        m.done = 1'b0;
        if (r) begin
            m.lfsr = 32'd1; m.taps = 32'h5 & mask; m.refs = 32'd1;
            m.cnt = 0; m.len = 0; m.run = 1'b0; m.stuck = 1'b0;
        end else if (ld) begin
            m.lfsr = sd & mask; m.taps = tp & mask; m.refs = sd & mask;
            m.cnt = 0; m.len = 0; m.run = 1'b0; m.stuck = ((sd & mask) == 0);
        end else if (m.run && halt) begin
            m.run = 1'b0;
        end else if (!m.run && !m.stuck && go) begin
            m.run = 1'b1;
        end else if (m.run && rdy) begin
            nxt   = model_next(w, m.lfsr, m.taps);
            m.lfsr = nxt;
            m.cnt  = (m.cnt + 1) & mask;
            if (nxt == 0) begin
                m.run = 1'b0; m.stuck = 1'b1;
            end
            if (nxt == m.refs) begin
                m.done = 1'b1; m.len = m.cnt; m.cnt = 0;
            end
        end
    endtask

    // Model advances on the same edge the DUTs do.
    always @(posedge clk) begin
        model_step(5, m5, rst, bus5.load, 32'(bus5.seed), 32'(bus5.taps_in),
                   bus5.start, bus5.stop, bus5.out_ready);
        model_step(8, m8, rst, bus8.load, 32'(bus8.seed), 32'(bus8.taps_in),
                   bus8.start, bus8.stop, bus8.out_ready);
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (checking) begin
            check_output("d5.state_o",   32'(bus5.state_o),   m5.lfsr);
            check_output("d5.out_bit",   32'(bus5.out_bit),   32'(model_parity(m5.lfsr & m5.taps)));
            check_output("d5.out_valid", 32'(bus5.out_valid), 32'(m5.run));
            check_output("d5.stuck",     32'(bus5.stuck),     32'(m5.stuck));
            check_output("d8.state_o",   32'(bus8.state_o),   m8.lfsr);
            check_output("d8.out_bit",   32'(bus8.out_bit),   32'(model_parity(m8.lfsr & m8.taps)));
            check_output("d8.out_valid", 32'(bus8.out_valid), 32'(m8.run));
            check_output("d8.stuck",     32'(bus8.stuck),     32'(m8.stuck));
`ifdef MSEQ_PERIOD_CNT_EN
            check_output("d5.period_done", 32'(bus5.period_done), 32'(m5.done));
            check_output("d5.period_len",  32'(bus5.period_len),  m5.len);
            check_output("d8.period_done", 32'(bus8.period_done), 32'(m8.done));
            check_output("d8.period_len",  32'(bus8.period_len),  m8.len);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one DUT's control inputs (which: 5 or 8).
    task automatic apply_stimulus(input int which, input logic ld,
                                  input logic [7:0] sd, input logic [7:0] tp,
                                  input logic go, input logic halt, input logic rdy);
        if (which == 5) begin
            bus5.load = ld; bus5.seed = sd[4:0]; bus5.taps_in = tp[4:0];
            bus5.start = go; bus5.stop = halt; bus5.out_ready = rdy;
        end else begin
            bus8.load = ld; bus8.seed = sd; bus8.taps_in = tp;
            bus8.start = go; bus8.stop = halt; bus8.out_ready = rdy;
        end
    endtask

    initial begin
        int first_hit;
        int pulses;
        n_vec = 0;
        n_err = 0;
        checking = 1'b0;
        first_hit = 0;
        pulses = 0;
        rst = 1'b1;
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 0);
        apply_stimulus(8, 0, 8'h00, 8'h00, 0, 0, 0);
        tick();
        checking = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        check_output("rst.state_o",   32'(bus5.state_o),   32'h01);
        check_output("rst.out_bit",   32'(bus5.out_bit),   32'h1);
        check_output("rst.out_valid", 32'(bus5.out_valid), 32'h0);
        check_output("rst.stuck",     32'(bus5.stuck),     32'h0);

        // Start, then a full 31-transfer lap
        apply_stimulus(5, 0, 8'h00, 8'h00, 1, 0, 1);
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 1);
        check_output("run.out_valid", 32'(bus5.out_valid), 32'h1);
        check_output("run.state0",    32'(bus5.state_o),   32'h01);
        for (int i = 1; i <= 31; i++) begin
            tick();
`ifdef MSEQ_PERIOD_CNT_EN
            if (bus5.period_done) pulses++;
`endif
            if (i == 1) check_output("run.state1", 32'(bus5.state_o), 32'h10);
        end
        check_output("lap.state_o", 32'(bus5.state_o), 32'h01);
`ifdef MSEQ_PERIOD_CNT_EN
        check_output("lap.pulses",     32'(pulses),          32'd1);
        check_output("lap.period_len", 32'(bus5.period_len), 32'd31);
`endif

        // Two more steps to 01000, then hold with out_ready low
        tick();
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 0);
        repeat (10) tick();
        check_output("hold.state_o",   32'(bus5.state_o),   32'h08);
        check_output("hold.out_bit",   32'(bus5.out_bit),   32'h0);
        check_output("hold.out_valid", 32'(bus5.out_valid), 32'h1);
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 1, 0);
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 0);
        check_output("stop.out_valid", 32'(bus5.out_valid), 32'h0);

        // Reset in the middle of a run discards the pending transfer
        apply_stimulus(5, 0, 8'h00, 8'h00, 1, 0, 1);
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 0);
        check_output("midrst.state_o",   32'(bus5.state_o),   32'h01);
        check_output("midrst.out_valid", 32'(bus5.out_valid), 32'h0);

        // Zero seed parks in STUCK; start ignored; nonzero seed recovers
        apply_stimulus(5, 1, 8'h00, 8'h05, 0, 0, 0);
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h05, 1, 0, 1);
        check_output("zseed.stuck", 32'(bus5.stuck), 32'h1);
        tick();
        check_output("zseed.out_valid", 32'(bus5.out_valid), 32'h0);
        check_output("zseed.stuck2",    32'(bus5.stuck),     32'h1);
        apply_stimulus(5, 1, 8'h03, 8'h05, 0, 0, 0);
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 0);
        check_output("reseed.stuck",     32'(bus5.stuck),     32'h0);
        check_output("reseed.out_valid", 32'(bus5.out_valid), 32'h0);
        check_output("reseed.state_o",   32'(bus5.state_o),   32'h03);

        // Zero taps drain the register into STUCK
        apply_stimulus(5, 1, 8'h01, 8'h00, 0, 0, 0);
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 1, 0, 0);
        tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 1);
        repeat (5) tick();
        apply_stimulus(5, 0, 8'h00, 8'h00, 0, 0, 0);
        check_output("ztap.state_o",   32'(bus5.state_o),   32'h00);
        check_output("ztap.stuck",     32'(bus5.stuck),     32'h1);
        check_output("ztap.out_valid", 32'(bus5.out_valid), 32'h0);

        // 8-bit maximal sequence, taps x^8+x^6+x^5+x^4+1
        apply_stimulus(8, 1, 8'h01, 8'h71, 0, 0, 0);
        tick();
        apply_stimulus(8, 0, 8'h00, 8'h00, 1, 0, 0);
        tick();
        apply_stimulus(8, 0, 8'h00, 8'h00, 0, 0, 1);
        for (int t = 1; t <= 300 && first_hit == 0; t++) begin
            tick();
            if (bus8.state_o == 8'h01) first_hit = t;
        end
        check_output("w8.period", 32'(first_hit), 32'd255);
`ifdef MSEQ_PERIOD_CNT_EN
        check_output("w8.period_len", 32'(bus8.period_len), 32'd255);
`endif
        repeat (4) tick();
        apply_stimulus(8, 1, 8'hA5, 8'h71, 0, 0, 1);
        tick();
        apply_stimulus(8, 0, 8'h00, 8'h00, 0, 0, 0);
        check_output("w8load.out_valid", 32'(bus8.out_valid), 32'h0);
        check_output("w8load.state_o",   32'(bus8.state_o),   32'hA5);
        check_output("w8load.stuck",     32'(bus8.stuck),     32'h0);
        repeat (2) tick();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
